// File: rtl/sysid_checker_pkg.sv
// Shared types and constants for the system-ID checker.
package sysid_checker_pkg;

  typedef enum logic [2:0] {
    IDLE, REQ_ID, LAT_ID, REQ_TS, LAT_TS, COMPARE, FAIL
  } state_e;

  localparam logic ADDR_ID        = 1'b0;
  localparam logic ADDR_TIMESTAMP = 1'b1;

  localparam logic [31:0] DEF_EXPECTED_ID        = 32'h0000_0000;
  localparam logic [31:0] DEF_EXPECTED_TIMESTAMP = 32'd1444995724;

  // Bits needed to hold 0..n; never less than one bit.
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sysid_checker_if.sv
// Avalon-MM read-only bus between the checker (master) and the system-ID slave.
interface sysid_checker_if;
  logic        address;
  logic        read;
  logic        waitrequest;
  logic [31:0] readdata;

  modport master (output address, read, input waitrequest, readdata);
  modport slave  (input address, read, output waitrequest, readdata);
endinterface

// File: rtl/sysid_checker_timeout.sv
// Loadable saturating down-counter; expired while the count sits at zero.
module sysid_checker_timeout #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         en,
  output logic         expired
);
  logic [W-1:0] cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                   cnt <= '0;
    else if (clear)              cnt <= '0;
    else if (load)               cnt <= load_value;
    else if (en && cnt != '0)    cnt <= cnt - 1'b1;
  end

  assign expired = (cnt == '0);
endmodule

// File: rtl/sysid_checker.sv
// Reads system-ID words 0/1 on start and compares them with the build's expected values.
// Optional SYSID_CHECKER_PERIODIC_EN adds automatic rechecks every RECHECK_PERIOD idle cycles.
module sysid_checker
  import sysid_checker_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID        = DEF_EXPECTED_ID,
  parameter logic [31:0] EXPECTED_TIMESTAMP = DEF_EXPECTED_TIMESTAMP,
  parameter int          READ_LATENCY       = 1,
  parameter int          TIMEOUT_CYCLES     = 255,
  parameter int          RETRY_MAX          = 2
`ifdef SYSID_CHECKER_PERIODIC_EN
  , parameter int        RECHECK_PERIOD     = 1_000_000
`endif
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  sysid_checker_if.master     bus,
  output logic [31:0]         id_value,
  output logic [31:0]         timestamp_value,
  output logic                busy,
  output logic                done,
  output logic                match,
  output logic                error
);
  localparam int TW   = cnt_w(TIMEOUT_CYCLES);
  localparam int RW   = cnt_w(RETRY_MAX);
  localparam bit LAT0 = (READ_LATENCY == 0);

  state_e        state, state_nxt;
  logic [RW-1:0] retry_cnt;
  logic [1:0]    lat_cnt;
  logic          tmo_expired, req, rd, accept, timeout, retry_ok;
  logic          lat_hit, cap_id, cap_ts, start_eff, go;

  assign req      = (state == REQ_ID) || (state == REQ_TS);
  // The cycle the stall budget runs out is the one cycle read is dropped.
  assign rd       = req && !tmo_expired;
  assign accept   = rd && !bus.waitrequest;
  assign timeout  = req && tmo_expired;
  assign retry_ok = (retry_cnt < RW'(RETRY_MAX));
  assign lat_hit  = (lat_cnt == 2'(READ_LATENCY));
  assign cap_id   = LAT0 ? (state == REQ_ID && accept) : (state == LAT_ID && lat_hit);
  assign cap_ts   = LAT0 ? (state == REQ_TS && accept) : (state == LAT_TS && lat_hit);
  assign go       = start_eff && (state == IDLE);

  always_comb begin
    state_nxt   = state;
    bus.read    = rd;
    bus.address = (state == REQ_TS) ? ADDR_TIMESTAMP : ADDR_ID;
    busy        = (state != IDLE);
    done        = (state == COMPARE) || (state == FAIL);
    case (state)
      IDLE:    if (go) state_nxt = REQ_ID;
      REQ_ID:  if (timeout)     state_nxt = retry_ok ? REQ_ID : FAIL;
               else if (accept) state_nxt = LAT0 ? REQ_TS : LAT_ID;
      LAT_ID:  if (lat_hit) state_nxt = REQ_TS;
      REQ_TS:  if (timeout)     state_nxt = retry_ok ? REQ_ID : FAIL;
               else if (accept) state_nxt = LAT0 ? COMPARE : LAT_TS;
      LAT_TS:  if (lat_hit) state_nxt = COMPARE;
      COMPARE: state_nxt = IDLE;
      FAIL:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      retry_cnt       <= '0;
      lat_cnt         <= '0;
      id_value        <= '0;
      timestamp_value <= '0;
      match           <= 1'b0;
      error           <= 1'b0;
    end else begin
      state <= state_nxt;
      if (go) begin
        retry_cnt <= '0;
        match     <= 1'b0;
        error     <= 1'b0;
      end
      if (timeout) begin
        if (retry_ok) retry_cnt <= retry_cnt + 1'b1;
        else          error     <= 1'b1;
      end
      if (accept)                                 lat_cnt <= 2'd1;
      else if (state == LAT_ID || state == LAT_TS) lat_cnt <= lat_cnt + 1'b1;
      if (cap_id) id_value <= bus.readdata;
      // Match is settled as the timestamp lands so it is valid alongside done.
      if (cap_ts) begin
        timestamp_value <= bus.readdata;
        match <= (id_value == EXPECTED_ID) && (bus.readdata == EXPECTED_TIMESTAMP);
      end
    end
  end

  sysid_checker_timeout #(.W(TW)) u_tmo (
    .clock      (clock),
    .reset      (reset),
    .clear      (1'b0),
    .load       (go || accept || timeout),
    .load_value (TW'(TIMEOUT_CYCLES)),
    .en         (rd && bus.waitrequest),
    .expired    (tmo_expired)
  );

`ifdef SYSID_CHECKER_PERIODIC_EN
  localparam int PW = cnt_w(RECHECK_PERIOD);
  logic armed, per_expired, auto_start;

  // Only a matching result keeps the periodic recheck alive.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                 armed <= 1'b0;
    else if (state == COMPARE) armed <= match;
    else if (state == FAIL)    armed <= 1'b0;
  end

  assign auto_start = armed && (state == IDLE) && per_expired;
  assign start_eff  = start || auto_start;

  sysid_checker_timeout #(.W(PW)) u_period (
    .clock      (clock),
    .reset      (reset),
    .clear      (1'b0),
    .load       ((state == COMPARE) || go),
    .load_value (PW'(RECHECK_PERIOD - 1)),
    .en         (armed && (state == IDLE)),
    .expired    (per_expired)
  );
`else
  assign start_eff = start;
`endif

endmodule

// File: tb/tb_sysid_checker.sv
// Scoreboard bench for sysid_checker: random slave data/stalls against a transaction-level model.
module tb_sysid_checker;
  localparam logic [31:0] EXP_ID = 32'h0000_0000;
  localparam logic [31:0] EXP_TS = 32'd1444995724;
  localparam int TMO  = 255;
  localparam int RMAX = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] id_value, timestamp_value;
  logic        busy, done, match, error;

  sysid_checker_if bus();

  sysid_checker dut (
    .clock           (clock),
    .reset           (reset),
    .start           (start),
    .bus             (bus),
    .id_value        (id_value),
    .timestamp_value (timestamp_value),
    .busy            (busy),
    .done            (done),
    .match           (match),
    .error           (error)
  );

  always #5 clock = ~clock;

  // Slave model configuration (written by stimulus only)
  logic [31:0] mem_id = '0, mem_ts = '0;
  int          stall_id = 0, stall_ts = 0;
  bit          stuck = 1'b0;
  // Slave-side state (written by the slave process only)
  int          cnt_id = 0, cnt_ts = 0, cyc = 0;

  assign bus.waitrequest = stuck ||
    (bus.read && (bus.address ? (cnt_ts < stall_ts) : (cnt_id < stall_id)));

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (start) begin
      cnt_id <= 0;
      cnt_ts <= 0;
    end else if (bus.read && bus.waitrequest) begin
      if (bus.address) cnt_ts <= cnt_ts + 1;
      else             cnt_id <= cnt_id + 1;
    end
    bus.readdata <= (bus.read && !bus.waitrequest) ? (bus.address ? mem_ts : mem_id) : $urandom();
  end

  typedef struct {
    logic [31:0] id;
    logic [31:0] ts;
    logic        m;
    logic        e;
    int          lat;
    int          st;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0, failures = 0;
  logic [31:0] last_id = '0, last_ts = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 3000 && busy; i++) @(negedge clock);
    chk("wait_idle", 32'(busy), 32'd0);
  endtask

  // mode 0: plain; 1: extra start while busy; 2: start raised in the done cycle
  task automatic run_check(input logic [31:0] id, input logic [31:0] ts,
                           input int sid, input int sts, input bit stk, input int mode);
    exp_t e;
    mem_id = id; mem_ts = ts; stall_id = sid; stall_ts = sts; stuck = stk;
    @(negedge clock);
    if (stk) begin
      e.e = 1'b1; e.m = 1'b0;
      e.lat = (RMAX + 1) * (TMO + 1) + 1;
    end else begin
      last_id = id; last_ts = ts;
      e.e = 1'b0;
      e.m = (id == EXP_ID) && (ts == EXP_TS);
      e.lat = 5 + sid + sts;
    end
    e.id = last_id; e.ts = last_ts; e.st = cyc;
    sb_q.push_back(e);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    if (mode == 1) begin
      @(negedge clock); start = 1'b1;
      @(negedge clock); start = 1'b0;
    end else if (mode == 2) begin
      for (int i = 0; i < 3000 && !done; i++) @(negedge clock);
      chk("done_seen", 32'(done), 32'd1);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      chk("start_at_done_ignored", 32'(busy), 32'd0);
    end
    wait_idle();
  endtask

  // Monitor: read/address stability under stall, and scoreboard on done
  initial begin
    bit   prev_rw;
    logic prev_addr;
    exp_t e;
    prev_rw = 1'b0;
    prev_addr = 1'b0;
    forever begin
      @(negedge clock);
      if (!reset && prev_rw && !stuck) begin
        chk("hold_read", 32'(bus.read), 32'd1);
        chk("hold_addr", 32'(bus.address), 32'(prev_addr));
      end
      prev_rw   = !reset && bus.read && bus.waitrequest;
      prev_addr = bus.address;
      if (!reset && done) begin
        if (sb_q.size() == 0) chk("unexpected_done", 32'(done), 32'd0);
        else begin
          e = sb_q.pop_front();
          chk("latency", 32'(cyc - e.st), 32'(e.lat));
          chk("id_value", id_value, e.id);
          chk("timestamp_value", timestamp_value, e.ts);
          chk("match", 32'(match), 32'(e.m));
          chk("error", 32'(error), 32'(e.e));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    repeat (2) @(negedge clock);
    chk("rst_read", 32'(bus.read), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_match", 32'(match), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_id", id_value, 32'd0);
    chk("rst_ts", timestamp_value, 32'd0);
    reset = 1'b0;
    @(negedge clock);

    run_check(EXP_ID, EXP_TS, 0, 0, 1'b0, 0);
    run_check(EXP_ID, EXP_TS + 32'd1, 0, 0, 1'b0, 0);
    run_check(EXP_ID, EXP_TS, 10, 0, 1'b0, 0);
    run_check(32'hdead_beef, EXP_TS, 3, 4, 1'b0, 0);
    run_check(EXP_ID, EXP_TS, 0, 0, 1'b0, 1);
    run_check(EXP_ID, 32'h1, 0, 0, 1'b0, 2);
    run_check(32'h5555_0000, EXP_TS, 0, 0, 1'b1, 0);
    run_check(EXP_ID, EXP_TS, 2, 0, 1'b0, 0);

    // reset while in LAT_TS
    mem_id = 32'h1234; mem_ts = EXP_TS; stall_id = 0; stall_ts = 0; stuck = 1'b0;
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (3) @(posedge clock);
    #2;
    chk("mid_busy", 32'(busy), 32'd1);
    chk("mid_id", id_value, 32'h1234);
    reset = 1'b1;
    #1;
    chk("rstmid_read", 32'(bus.read), 32'd0);
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_id", id_value, 32'd0);
    chk("rstmid_ts", timestamp_value, 32'd0);
    last_id = '0; last_ts = '0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    run_check(EXP_ID, EXP_TS, 0, 0, 1'b0, 0);

    for (int n = 0; n < 20; n++) begin
      logic [31:0] rid, rts;
      rid = ($urandom_range(0, 1) == 0) ? EXP_ID : $urandom();
      rts = ($urandom_range(0, 1) == 0) ? EXP_TS : (EXP_TS ^ (32'd1 << $urandom_range(0, 31)));
      run_check(rid, rts, $urandom_range(0, 6), $urandom_range(0, 6),
                ($urandom_range(0, 9) == 0), 0);
    end

    repeat (5) @(negedge clock);
    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
